lms_coeff_update: RTL and testbench

LMS coefficient-adaptation stage downstream of the FIR datapath. On each valid filter output it forms the error against a desired sample. It then updates every active tap weight with a sign-preserving, shift-scaled LMS step and streams the new weights back to the FIR coefficient port, one per cycle, in tap order. It keeps its own input-sample history, so the update uses the same x[n-i] the filter used.

---
 rtl/lms_pkg.sv | 24 ++
 rtl/lms_coeff_update_history.sv | 34 +++
 rtl/lms_coeff_update.sv | 124 ++++++++++++
 tb/tb_lms_coeff_update.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lms_pkg.sv
// Shared types, Q-format constants and saturation helpers for the LMS coefficient-update stage.
package lms_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        UPDATE
    } state_t;

    localparam int Q_IN  = 15;
    localparam int Q_ACC = 30;

    function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767)  return 16'sh7fff;
        if (v < -33'sd32768) return 16'sh8000;
        return v[15:0];
    endfunction

    function automatic logic signed [31:0] sat32(input logic signed [32:0] v);
        if (v[32] != v[31]) return v[32] ? 32'sh8000_0000 : 32'sh7fff_ffff;
        return v[31:0];
    endfunction

endpackage

// File: rtl/lms_coeff_update_history.sv
// Input-sample delay line (h[0] newest) with a snapshot taken on accept,
// so the weight update sees the same x[n-i] the filter used.
module lms_history
    import lms_pkg::*;
#(
    parameter int MAX_TAPS = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               x_valid,
    input  logic signed [15:0] x_data,
    input  logic               snap_en,
    output logic signed [15:0] snap [MAX_TAPS]
);

    logic signed [15:0] hist [MAX_TAPS];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < MAX_TAPS; k++) begin
                hist[k] <= '0;
                snap[k] <= '0;
            end
        end else begin
            if (x_valid) begin
                hist[0] <= x_data;
                for (int k = 1; k < MAX_TAPS; k++) hist[k] <= hist[k-1];
            end
            // Non-blocking read of hist gives the pre-shift contents of this cycle.
            if (snap_en) snap <= hist;
        end
    end

endmodule

// File: rtl/lms_coeff_update.sv
// LMS coefficient adaptation: forms d - y on each accepted FIR output, then updates
// and streams tap weights w[0..tc-1] one per cycle through a single shared multiplier.
module lms_coeff_update
    import lms_pkg::*;
#(
    parameter int MAX_TAPS = 16,
    parameter int MU_SHIFT = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        enable,
    input  logic [$clog2(MAX_TAPS)-1:0] tap_count,
    input  logic                        x_valid,
    input  logic signed [15:0]          x_data,
    input  logic                        fir_out_valid,
    input  logic signed [31:0]          fir_out_data,
    input  logic signed [15:0]          desired_data,
    output logic                        err_valid,
    output logic signed [31:0]          err_out,
    output logic                        coeff_restart,
    output logic                        coeff_data_valid,
    output logic signed [15:0]          coeff_data,
    output logic                        busy,
    output logic [7:0]                  dropped
);

    localparam int AW = $clog2(MAX_TAPS);

    state_t             state, state_nx;
    logic [AW-1:0]      idx, tc_q;
    logic signed [31:0] y_q;
    logic signed [15:0] d_q;
    logic signed [15:0] w    [MAX_TAPS];
    logic signed [15:0] snap [MAX_TAPS];

    logic               accept, last_tap;
    logic signed [32:0] err_full, err_ext, w_sum;
    logic signed [31:0] err_sat, prod, prod_sh;
    logic signed [15:0] e15, delta, w_new;

    assign accept   = fir_out_valid && enable && (state == IDLE);
    assign busy     = (state != IDLE);
    assign last_tap = (idx == tc_q - AW'(1));

    lms_history #(.MAX_TAPS(MAX_TAPS)) u_history (
        .clk     (clk),
        .rstn    (rstn),
        .x_valid (x_valid),
        .x_data  (x_data),
        .snap_en (accept),
        .snap    (snap)
    );

    // Error in Q30: desired is promoted from Q15 before the subtraction.
    assign err_full = (33'(d_q) <<< (Q_ACC - Q_IN)) - 33'(y_q);
    assign err_sat  = sat32(err_full);
    assign err_ext  = 33'(err_out);
    assign e15      = sat16(err_ext >>> Q_IN);

    assign prod    = e15 * snap[idx];
    assign prod_sh = prod >>> (Q_IN + MU_SHIFT);
    assign delta   = sat16(33'(prod_sh));
    assign w_sum   = 33'(w[idx]) + 33'(delta);
    assign w_new   = sat16(w_sum);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = CAPTURE;
            CAPTURE: state_nx = (tc_q != '0) ? UPDATE : IDLE;
            UPDATE:  if (last_tap) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state            <= IDLE;
            idx              <= '0;
            tc_q             <= '0;
            y_q              <= '0;
            d_q              <= '0;
            err_out          <= '0;
            err_valid        <= 1'b0;
            coeff_restart    <= 1'b0;
            coeff_data       <= '0;
            coeff_data_valid <= 1'b0;
            dropped          <= '0;
            // NOTE: the weight array is cleared on reset, so it must stay in flops rather than a RAM macro.
            for (int k = 0; k < MAX_TAPS; k++) w[k] <= '0;
        end else begin
            state            <= state_nx;
            err_valid        <= 1'b0;
            coeff_restart    <= 1'b0;
            coeff_data_valid <= 1'b0;

            if (accept) begin
                y_q  <= fir_out_data;
                d_q  <= desired_data;
                tc_q <= tap_count;
            end

            if (fir_out_valid && enable && busy && dropped != 8'hff)
                dropped <= dropped + 8'd1;

            case (state)
                CAPTURE: begin
                    err_out       <= err_sat;
                    err_valid     <= 1'b1;
                    coeff_restart <= (tc_q != '0);
                    idx           <= '0;
                end
                UPDATE: begin
                    w[idx]           <= w_new;
                    coeff_data       <= w_new;
                    coeff_data_valid <= 1'b1;
                    idx              <= idx + AW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lms_coeff_update.sv
// Randomized self-checking bench for lms_coeff_update against an arithmetic LMS reference model.
module tb_lms_coeff_update;

    localparam int MAX_TAPS = 16;
    localparam int MU_SHIFT = 4;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               enable = 1'b0;
    logic [3:0]         tap_count = '0;
    logic               x_valid = 1'b0;
    logic signed [15:0] x_data = '0;
    logic               fir_out_valid = 1'b0;
    logic signed [31:0] fir_out_data = '0;
    logic signed [15:0] desired_data = '0;
    logic               err_valid;
    logic signed [31:0] err_out;
    logic               coeff_restart;
    logic               coeff_data_valid;
    logic signed [15:0] coeff_data;
    logic               busy;
    logic [7:0]         dropped;

    int n_cmp = 0;
    int n_bad = 0;
    int h_m [MAX_TAPS];
    int w_m [MAX_TAPS];
    int drop_m = 0;

    lms_coeff_update #(.MAX_TAPS(MAX_TAPS), .MU_SHIFT(MU_SHIFT)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .enable           (enable),
        .tap_count        (tap_count),
        .x_valid          (x_valid),
        .x_data           (x_data),
        .fir_out_valid    (fir_out_valid),
        .fir_out_data     (fir_out_data),
        .desired_data     (desired_data),
        .err_valid        (err_valid),
        .err_out          (err_out),
        .coeff_restart    (coeff_restart),
        .coeff_data_valid (coeff_data_valid),
        .coeff_data       (coeff_data),
        .busy             (busy),
        .dropped          (dropped)
    );

    always #5 clk = ~clk;

    function automatic longint m_sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint m_sat32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < MAX_TAPS; k++) begin
            h_m[k] = 0;
            w_m[k] = 0;
        end
        drop_m = 0;
    endtask

    task automatic model_shift(input int v);
        for (int k = MAX_TAPS - 1; k > 0; k--) h_m[k] = h_m[k-1];
        h_m[0] = v;
    endtask

    task automatic push_x(input int v);
        x_valid = 1'b1;
        x_data  = 16'(v);
        @(negedge clk);
        x_valid = 1'b0;
        model_shift(v);
    endtask

    // One accepted FIR output at cycle T, followed by the full response window.
    task automatic run_event(input string tag, input int tc, input int y, input int d,
                             input int n_drops, input int n_x);
        int     exp_w [MAX_TAPS];
        longint e, p;
        int     e15, dl, exp_drop, v;
        logic [15:0] ew;
        e   = m_sat32(longint'(d) * 32768 - longint'(y));
        e15 = int'(m_sat16(e >>> 15));
        for (int i = 0; i < tc; i++) begin
            p  = longint'(e15) * longint'(h_m[i]);
            dl = int'(m_sat16(p >>> (15 + MU_SHIFT)));
            w_m[i]   = int'(m_sat16(longint'(w_m[i]) + longint'(dl)));
            exp_w[i] = w_m[i];
        end
        exp_drop = (drop_m + n_drops > 255) ? 255 : drop_m + n_drops;

        enable        = 1'b1;
        fir_out_valid = 1'b1;
        fir_out_data  = y;
        desired_data  = 16'(d);
        tap_count     = 4'(tc);
        for (int k = 1; k <= 2 + tc; k++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== (k <= 1 + tc)) begin
                n_bad++;
                $display("FAIL %s busy T+%0d: got %b want %b", tag, k, busy, (k <= 1 + tc));
            end
            n_cmp++;
            if (err_valid !== (k == 2)) begin
                n_bad++;
                $display("FAIL %s err_valid T+%0d: got %b want %b", tag, k, err_valid, (k == 2));
            end
            n_cmp++;
            if (coeff_restart !== (k == 2 && tc > 0)) begin
                n_bad++;
                $display("FAIL %s coeff_restart T+%0d: got %b want %b", tag, k, coeff_restart, (k == 2 && tc > 0));
            end
            n_cmp++;
            if (coeff_data_valid !== (k >= 3)) begin
                n_bad++;
                $display("FAIL %s coeff_data_valid T+%0d: got %b want %b", tag, k, coeff_data_valid, (k >= 3));
            end
            if (k == 2) begin
                n_cmp++;
                if (err_out !== e[31:0]) begin
                    n_bad++;
                    $display("FAIL %s err_out: got %h want %h", tag, err_out, e[31:0]);
                end
            end
            if (k >= 3) begin
                ew = 16'(exp_w[k-3]);
                n_cmp++;
                if (coeff_data !== ew) begin
                    n_bad++;
                    $display("FAIL %s coeff_data w[%0d]: got %0d want %0d", tag, k - 3, coeff_data, $signed(ew));
                end
            end
            // Stimulus for cycle T+k: drops, history writes and a tap_count that must be ignored.
            fir_out_valid = (k >= 2 && k - 2 < n_drops);
            tap_count     = 4'($urandom);
            x_valid       = (k >= 2 && k - 2 < n_x);
            if (x_valid) begin
                v      = rnd16();
                x_data = 16'(v);
                model_shift(v);
            end
        end
        @(negedge clk);
        fir_out_valid = 1'b0;
        x_valid       = 1'b0;
        n_cmp++;
        if (coeff_data_valid !== 1'b0 || err_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s tail strobes: got cdv=%b ev=%b want 0 0", tag, coeff_data_valid, err_valid);
        end
        n_cmp++;
        if (dropped !== 8'(exp_drop)) begin
            n_bad++;
            $display("FAIL %s dropped: got %0d want %0d", tag, dropped, exp_drop);
        end
        drop_m = exp_drop;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({err_valid, coeff_restart, coeff_data_valid, busy} !== 4'b0 ||
            err_out !== '0 || coeff_data !== '0 || dropped !== '0) begin
            n_bad++;
            $display("FAIL reset outputs: ev=%b cr=%b cdv=%b busy=%b err=%h cd=%h drop=%0d want all 0",
                     err_valid, coeff_restart, coeff_data_valid, busy, err_out, coeff_data, dropped);
        end
        rstn = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single_tap();
        push_x(16384);
        run_event("single_tap", 1, 0, 16384, 0, 0);
    endtask

    task automatic test_four_taps();
        push_x(-400);
        push_x(300);
        push_x(-200);
        push_x(100);
        run_event("four_taps_a", 4, 0, 8192, 0, 0);
        run_event("four_taps_b", 4, 0, 8192, 0, 0);
    endtask

    task automatic test_saturation();
        push_x(32767);
        for (int n = 0; n < 20; n++) run_event("sat_pos", 1, int'(32'h8000_0000), 32767, 0, 0);
        for (int n = 0; n < 40; n++) run_event("sat_neg", 1, int'(32'h7fff_ffff), -32768, 0, 0);
    endtask

    task automatic test_busy_drop();
        for (int n = 0; n < 8; n++) push_x(rnd16());
        run_event("busy_drop", 8, $signed($urandom) >>> 4, rnd16(), 3, 2);
    endtask

    task automatic test_tc_zero();
        run_event("tc_zero", 0, $signed($urandom) >>> 2, rnd16(), 0, 0);
    endtask

    task automatic test_enable_low();
        enable        = 1'b0;
        fir_out_valid = 1'b1;
        fir_out_data  = $signed($urandom);
        desired_data  = 16'(rnd16());
        tap_count     = 4'd5;
        @(negedge clk);
        fir_out_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if ({err_valid, coeff_restart, coeff_data_valid, busy} !== 4'b0 || dropped !== 8'(drop_m)) begin
                n_bad++;
                $display("FAIL enable_low T+%0d: ev=%b cr=%b cdv=%b busy=%b drop=%0d want 0 0 0 0 %0d",
                         k, err_valid, coeff_restart, coeff_data_valid, busy, dropped, drop_m);
            end
            @(negedge clk);
        end
        enable = 1'b1;
    endtask

    task automatic test_random();
        int tc, nd, nx;
        for (int n = 0; n < 30; n++) begin
            for (int j = 0; j < int'($urandom_range(3)); j++) push_x(rnd16());
            tc = int'($urandom_range(15));
            nd = int'($urandom_range((tc < 3) ? tc : 3));
            nx = int'($urandom_range((tc < 2) ? tc : 2));
            run_event("random", tc, $signed($urandom) >>> $urandom_range(8), rnd16(), nd, nx);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int n = 0; n < 8; n++) push_x(rnd16());
        enable        = 1'b1;
        fir_out_valid = 1'b1;
        fir_out_data  = $signed($urandom) >>> 3;
        desired_data  = 16'(rnd16());
        tap_count     = 4'd8;
        @(negedge clk);
        fir_out_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (coeff_data_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_burst started T+3: cdv got %b want 1", coeff_data_valid);
        end
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({err_valid, coeff_restart, coeff_data_valid, busy} !== 4'b0 ||
            err_out !== '0 || coeff_data !== '0 || dropped !== '0) begin
            n_bad++;
            $display("FAIL mid_burst reset T+5: ev=%b cr=%b cdv=%b busy=%b err=%h cd=%h drop=%0d want all 0",
                     err_valid, coeff_restart, coeff_data_valid, busy, err_out, coeff_data, dropped);
        end
        rstn = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (coeff_data_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_burst after reset: cdv=%b busy=%b want 0 0", coeff_data_valid, busy);
            end
        end
        push_x(16384);
        run_event("post_reset_tap0", 1, 0, 16384, 0, 0);
        run_event("post_reset_all", 8, $signed($urandom) >>> 4, rnd16(), 0, 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_tap();
        test_four_taps();
        test_saturation();
        test_busy_drop();
        test_tc_zero();
        test_enable_low();
        test_random();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
